// File: rtl/uart_rx.sv
// uart_rx -- asynchronous serial receiver (8N1, or 8E1 with parity).
//
// Recovers frames from the idle-high serial line, samples each bit at
// mid-period and presents good bytes on a valid/ready holding register.
// Framing, parity and overrun errors are reported as one-cycle pulses.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> 11-bit frame (start, 8 data, even parity, stop), parity_err live
//   undefined -> 10-bit frame, parity_err tied 0
//
// Parameters
//   CLKS_PER_BIT  clock cycles per bit; even and >= 8
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   rxd         serial line, asynchronous to clk
//   rx_data     received byte (LSB = first data bit on the wire)
//   rx_valid    rx_data holds an unconsumed byte
//   rx_ready    consumer takes rx_data when rx_valid && rx_ready
//   busy        receiver is not idle
//   frame_err   pulse: stop bit sampled low, byte discarded
//   parity_err  pulse: parity mismatch, byte discarded
//   overrun     pulse: good byte dropped because the holding register was full
module uart_rx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun
);

    localparam int            CW       = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        state_q, state_n;
    logic [1:0]    sync_q;
    logic          rxs, rxs_d, fall;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          stop_q;
    logic          tick;
    logic          done, take, good, load, fe_d, ov_d, par_bad;

    // ------------------------------------------------------------------
    // Input synchronizer plus one extra stage for falling-edge detection.
    // Requiring a real high->low edge also keeps a break (line held low
    // after a frame error) from ever starting a new frame.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            rxs_d  <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], rxd};
            rxs_d  <= sync_q[1];
        end
    end

    assign rxs  = sync_q[1];
    assign fall = rxs_d & ~rxs;

    // Sample strobe: half a bit into START, then once per bit period.
    always_comb begin
        tick = 1'b0;
        case (state_q)
            S_START:        tick = (cnt_q == CNT_HALF);
            S_DATA, S_STOP: tick = (cnt_q == CNT_LAST);
`ifdef UART_RX_PARITY_EN
            S_PARITY:       tick = (cnt_q == CNT_LAST);
`endif
            default:        tick = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_n;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // STOP lingers one cycle past its sample (cnt == CLKS_PER_BIT) so the
    // commit/error decision is registered on the way back to IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE:  if (fall) state_n = S_START;
            S_START: if (tick) state_n = rxs ? S_IDLE : S_DATA;
            S_DATA: begin
                if (tick && bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    state_n = S_PARITY;
`else
                    state_n = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (tick) state_n = S_STOP;
`endif
            S_STOP:  if (cnt_q == CNT_DONE) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Bit timing counter and shift datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            stop_q  <= 1'b0;
        end else begin
            // Restart the period on every state change and on each data
            // sample; STOP keeps counting past its sample to CNT_DONE.
            if (state_q == S_IDLE || state_n != state_q || (tick && state_q == S_DATA))
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + 1'b1;

            if (state_q == S_IDLE) begin
                bit_q <= '0;
            end else if (state_q == S_DATA && tick) begin
                shift_q <= {rxs, shift_q[7:1]};
                bit_q   <= bit_q + 1'b1;
            end

            if (state_q == S_STOP && tick)
                stop_q <= rxs;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_q;
    logic pe_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       par_q <= 1'b0;
        else if (state_q == S_PARITY && tick) par_q <= rxs;
    end

    // Even parity: data bits plus parity bit must have an even count of ones.
    assign par_bad = ^{shift_q, par_q};
    // A bad stop bit takes precedence over a parity error.
    assign pe_d    = done && stop_q && par_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) parity_err <= 1'b0;
        else        parity_err <= pe_d;
    end
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: outputs / commit decision
    // ------------------------------------------------------------------
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_STOP) && (cnt_q == CNT_DONE);
        take = rx_valid && rx_ready;
        fe_d = done && !stop_q;
        good = done && stop_q && !par_bad;
        // A byte consumed on the commit cycle frees the slot for the new one.
        load = good && (!rx_valid || take);
        ov_d = good && !load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
            end else if (take) begin
                rx_valid <= 1'b0;
            end
            frame_err <= fe_d;
            overrun   <= ov_d;
        end
    end

endmodule
